// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types and constants for the MAC sequencer
package mac_pkg;

    localparam int OPND_W     = 8;
    localparam int ACC_W      = 24;
    localparam int MAC_EN_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        OUT
    } mac_seq_state_e;

endpackage

// File: rtl/mac_en_pipe.sv
// rtl/mac_en_pipe.sv - DEPTH-deep 1-bit delay line with synchronous flush
// Ports: clk, rst_n (async, active-low), flush (clears every stage),
//        din (bit entering stage 0), dout (bit leaving the last stage).
module mac_en_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - job sequencer for one 8x8 MAC with 24-bit accumulator
// Ports: clk, rst_n (async, active-low)
//        start/len/abort/busy      job control
//        a_*/b_*                   show-ahead operand FIFOs (empty, head, pop)
//        mac_Ain/mac_Bin/mac_En/mac_Clr/mac_Cout   MAC datapath interface
//        result/result_vld/result_rdy              dot-product result handshake
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int LEN_W  = 8,
    parameter int EN_LAT = MAC_EN_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    output logic              busy,
    input  logic              a_empty,
    input  logic [OPND_W-1:0] a_data,
    output logic              a_rden,
    input  logic              b_empty,
    input  logic [OPND_W-1:0] b_data,
    output logic              b_rden,
    output logic [OPND_W-1:0] mac_Ain,
    output logic [OPND_W-1:0] mac_Bin,
    output logic              mac_En,
    output logic              mac_Clr,
    input  logic [ACC_W-1:0]  mac_Cout,
    output logic [ACC_W-1:0]  result,
    output logic              result_vld,
    input  logic              result_rdy
);

    localparam int DCNT_W = $clog2(EN_LAT + 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(EN_LAT);

    mac_seq_state_e    state, state_nx;
    logic [LEN_W-1:0]  remaining;
    logic [DCNT_W-1:0] drain_cnt;
    logic              pop;
    logic              drain_done;

    assign drain_done = (state == DRAIN) && (drain_cnt == DRAIN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        mac_Clr    = 1'b0;
        result_vld = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: begin
                mac_Clr  = 1'b1;
                state_nx = (remaining == '0) ? DRAIN : RUN;
            end
            RUN: begin
                // Both FIFOs must have data; a lone non-empty side never pops.
                pop = !a_empty && !b_empty && (remaining != '0);
                if (pop && remaining == LEN_W'(1)) state_nx = DRAIN;
            end
            DRAIN: begin
                if (drain_done) state_nx = OUT;
            end
            OUT: begin
                result_vld = 1'b1;
                if (result_rdy) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort overrides everything, including a start or clear in flight;
        // the accumulator keeps its value until the next job's CLEAR.
        if (abort) begin
            state_nx = IDLE;
            pop      = 1'b0;
            mac_Clr  = 1'b0;
        end
    end

    assign busy   = (state != IDLE);
    assign a_rden = pop;
    assign b_rden = pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            drain_cnt <= '0;
            mac_Ain   <= '0;
            mac_Bin   <= '0;
            result    <= '0;
        end else begin
            if (state == IDLE && start && !abort) begin
                remaining <= len;
            end
            if (pop) begin
                mac_Ain   <= a_data;
                mac_Bin   <= b_data;
                remaining <= remaining - LEN_W'(1);
            end
            drain_cnt <= (state == DRAIN && !drain_done && !abort) ?
                         drain_cnt + DCNT_W'(1) : '0;
            // EN_LAT+1 drain cycles: the last En has landed in mac_Cout by now.
            if (drain_done && !abort) begin
                result <= mac_Cout;
            end
        end
    end

    // En follows pop through the operand and multiplier register stages.
    mac_en_pipe #(
        .DEPTH (EN_LAT)
    ) u_en_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (mac_Clr || abort),
        .din   (pop),
        .dout  (mac_En)
    );

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - self-checking bench for mac_seq_ctrl
module tb_mac_seq_ctrl;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        abort = 1'b0;
    logic        busy;
    logic        a_empty = 1'b1;
    logic [7:0]  a_data = '0;
    logic        a_rden;
    logic        b_empty = 1'b1;
    logic [7:0]  b_data = '0;
    logic        b_rden;
    logic [7:0]  mac_Ain, mac_Bin;
    logic        mac_En, mac_Clr;
    logic [23:0] mac_Cout = '0;
    logic [23:0] result;
    logic        result_vld;
    logic        result_rdy = 1'b0;

    mac_seq_ctrl #(.LEN_W(8), .EN_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .busy(busy), .a_empty(a_empty), .a_data(a_data), .a_rden(a_rden),
        .b_empty(b_empty), .b_data(b_data), .b_rden(b_rden),
        .mac_Ain(mac_Ain), .mac_Bin(mac_Bin), .mac_En(mac_En), .mac_Clr(mac_Clr),
        .mac_Cout(mac_Cout), .result(result), .result_vld(result_vld),
        .result_rdy(result_rdy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Environment: FIFO queues and a behavioural MAC (registered multiplier,
    // accumulator cleared by Clr, adds the registered product on En).
    logic [7:0]  a_q[$];
    logic [7:0]  b_q[$];
    logic [23:0] acc = '0, acc_nx = '0;
    logic [15:0] prod = '0, prod_nx = '0;
    bit          pop_n = 0;
    bit          d1 = 0, d2 = 0;
    int          stall_at = -1, stall_cnt = 0;
    bit          rnd_bub = 0, b_bub = 0;
    int          cyc = 0, job_pops = 0, job_ens = 0, proto_err = 0;
    int          t_clr = -1, t_fp = -1, t_lp = -1, t_fe = -1, t_vld = -1;

    // Monitor: sample settled outputs mid-cycle.
    always @(negedge clk) begin
        pop_n = a_rden && b_rden;
        if (a_rden !== b_rden) proto_err++;
        if (a_rden && (a_empty || b_empty)) proto_err++;
        // En must be the pop of two cycles earlier, zeroed by Clr/abort/reset.
        if (mac_En !== d2) proto_err++;
        d2 = d1;
        d1 = pop_n;
        if (mac_Clr || abort || !rst_n) begin
            d1 = 0;
            d2 = 0;
        end
        acc_nx  = mac_Clr ? 24'd0 : (mac_En ? acc + {8'd0, prod} : acc);
        prod_nx = mac_Ain * mac_Bin;
        if (pop_n) begin
            job_pops++;
            if (t_fp < 0) t_fp = cyc;
            t_lp = cyc;
        end
        if (mac_En) begin
            job_ens++;
            if (t_fe < 0) t_fe = cyc;
        end
        if (mac_Clr && t_clr < 0) t_clr = cyc;
        if (result_vld && t_vld < 0) t_vld = cyc;
    end

    // Apply the edge's effects just after it.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_n && a_q.size() > 0) void'(a_q.pop_front());
        if (pop_n && b_q.size() > 0) void'(b_q.pop_front());
        acc      = acc_nx;
        prod     = prod_nx;
        mac_Cout = acc;
        if (stall_cnt > 0) stall_cnt--;
        if (pop_n && job_pops == stall_at) stall_cnt = 3;
        b_bub   = rnd_bub && ($urandom_range(0, 3) == 0);
        a_empty = (a_q.size() == 0) || (stall_cnt != 0);
        b_empty = (b_q.size() == 0) || b_bub;
        a_data  = (a_q.size() > 0) ? a_q[0] : 8'd0;
        b_data  = (b_q.size() > 0) ? b_q[0] : 8'd0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_job(input int n, input int exp_res, input bit chk_lat,
                           input int hold, input string tag);
        int t_start, waited, unstable;
        logic [23:0] held;
        job_pops = 0; job_ens = 0;
        t_clr = -1; t_fp = -1; t_lp = -1; t_fe = -1; t_vld = -1;
        start = 1'b1; len = n[7:0]; t_start = cyc;
        tick();
        start = 1'b0;
        waited = 0;
        while (!result_vld && waited < 3000) begin
            tick();
            waited++;
        end
        if (!result_vld) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        held = result;
        unstable = 0;
        for (int k = 0; k < hold; k++) begin
            start = 1'($urandom_range(0, 1));
            len   = 8'($urandom_range(0, 255));
            tick();
            if (!result_vld || result !== held) unstable++;
        end
        start = 1'b0;
        if (hold > 0) chk({tag, "_hold_stable"}, unstable, 0);
        result_rdy = 1'b1;
        chk({tag, "_result"}, int'(result), exp_res);
        tick();
        result_rdy = 1'b0;
        chk({tag, "_vld_drop"}, int'(result_vld), 0);
        chk({tag, "_busy_drop"}, int'(busy), 0);
        chk({tag, "_pops"}, job_pops, n);
        chk({tag, "_ens"}, job_ens, n);
        chk({tag, "_proto"}, proto_err, 0);
        if (chk_lat) begin
            chk({tag, "_clr_lat"}, t_clr - t_start, 1);
            if (n > 0) begin
                chk({tag, "_pop_lat"}, t_fp - t_start, 2);
                chk({tag, "_en_lat"}, t_fe - t_fp, 2);
                chk({tag, "_vld_lat"}, t_vld - t_lp, 4);
            end else begin
                chk({tag, "_vld_lat"}, t_vld - t_start, 5);
            end
        end
    endtask

    task automatic push_pair(input int a, input int b);
        a_q.push_back(8'(a));
        b_q.push_back(8'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, s, w;
        repeat (3) tick();
        chk("rst_ctl", int'({busy, a_rden, b_rden, mac_En, mac_Clr, result_vld}), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_opnd", int'({mac_Ain, mac_Bin}), 0);
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
        tick();
        run_job(4, 70, 1, 0, "t1_basic");

        for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
        stall_at = 2;
        tick();
        run_job(4, 70, 1, 0, "t2_stall");
        chk("t2_gap", t_lp - t_fp, 6);
        stall_at = -1;

        for (int i = 0; i < 255; i++) push_pair(255, 255);
        tick();
        run_job(255, 24'hFD02FF, 1, 0, "t3_max");

        push_pair(9, 9);
        tick();
        run_job(0, 0, 1, 0, "t4_zero");
        chk("t4_fifo_untouched", a_q.size(), 1);
        a_q.delete(); b_q.delete();

        push_pair(2, 4); push_pair(3, 5); push_pair(10, 10);
        tick();
        run_job(2, 23, 1, 0, "t5_job1");
        run_job(1, 100, 1, 0, "t5_job2");

        // Abort after 2 of 4 pops.
        for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
        tick();
        job_pops = 0;
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        w = 0;
        while (job_pops < 2 && w < 50) begin
            tick();
            w++;
        end
        chk("t6_reach_two", job_pops, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_idle", int'(busy), 0);
        chk("t6_rden", int'(a_rden), 0);
        job_pops = 0; job_ens = 0;
        repeat (6) tick();
        chk("t6_no_pops", job_pops, 0);
        chk("t6_no_ens", job_ens, 0);
        chk("t6_fifo_left", a_q.size(), 2);
        a_q.delete(); b_q.delete();
        push_pair(3, 3);
        tick();
        run_job(1, 9, 1, 0, "t6_after");

        // Abort and start together: abort wins.
        start = 1'b1; abort = 1'b1; len = 8'd3;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", int'(busy), 0);

        for (int i = 0; i < 4; i++) push_pair(i + 1, i + 5);
        tick();
        run_job(4, 70, 1, 5, "t7_hold");

        // Reset mid-job.
        for (int i = 0; i < 4; i++) push_pair(1, 1);
        tick();
        start = 1'b1; len = 8'd4;
        tick();
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_rden", int'(a_rden), 0);
        n = a_q.size();
        tick(); tick();
        chk("rst_mid_no_pop", a_q.size(), n);
        rst_n = 1'b1;
        a_q.delete(); b_q.delete();
        tick(); tick();

        // Randomised jobs with random B-side bubbles and result back-pressure.
        rnd_bub = 1;
        for (int j = 0; j < 8; j++) begin
            n = $urandom_range(0, 24);
            s = 0;
            for (int i = 0; i < n; i++) begin
                int av, bv;
                av = $urandom_range(0, 255);
                bv = $urandom_range(0, 255);
                push_pair(av, bv);
                s = (s + av * bv) & 32'h00FF_FFFF;
            end
            tick();
            run_job(n, s, 0, $urandom_range(0, 3), "rnd");
        end
        rnd_bub = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
